// File: rtl/iob_axi_m_bridge_pkg.sv
// Shared types and AXI constants for the iob-to-AXI4 master bridge.
// The bridge FSM states and the fixed AXI field encodings live here.
package iob_axi_m_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_W32   = 3'd2;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob_axi_m_bridge_if.sv
// Native iob request port plus AXI4 master channels, bundled as one bus.
// The master modport is the bridge view; slave is the requester/AXI-memory view.
interface iob_axi_m_bridge_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_LEN_W  = 8
);

  logic                    valid;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W/8-1:0]     wstrb;
  logic [DATA_W-1:0]       rdata;
  logic                    ready;
  logic                    error;

  logic [AXI_ID_W-1:0]     m_axi_awid;
  logic [AXI_ADDR_W-1:0]   m_axi_awaddr;
  logic [AXI_LEN_W-1:0]    m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;

  logic [DATA_W-1:0]       m_axi_wdata;
  logic [DATA_W/8-1:0]     m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;

  logic [AXI_ID_W-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  logic [AXI_ID_W-1:0]     m_axi_arid;
  logic [AXI_ADDR_W-1:0]   m_axi_araddr;
  logic [AXI_LEN_W-1:0]    m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;

  logic [AXI_ID_W-1:0]     m_axi_rid;
  logic [DATA_W-1:0]       m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  valid, addr, wdata, wstrb,
    output rdata, ready, error,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output valid, addr, wdata, wstrb,
    input  rdata, ready, error,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/iob_axi_m_bridge.sv
// Turns single-word iob native requests into single-beat AXI4 transactions,
// one outstanding at a time, with a sticky error flag for non-OKAY responses.
module iob_axi_m_bridge
  import iob_axi_m_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID     = 0
) (
  input  logic               clk,
  input  logic               rst,
  iob_axi_m_bridge_if.master bus
);

  state_t                  state_reg, state_next;
  logic                    aw_done_reg, aw_done_next;
  logic                    w_done_reg, w_done_next;
  logic [AXI_ADDR_W-3:0]   word_addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [DATA_W/8-1:0]     wstrb_reg;
  logic [DATA_W-1:0]       rdata_reg, rdata_next;
  logic                    error_reg, error_next;
  logic                    capture_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      word_addr_reg <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rdata_reg     <= '0;
      error_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      rdata_reg   <= rdata_next;
      error_reg   <= error_next;
      if (capture_req) begin
        word_addr_reg <= bus.addr[AXI_ADDR_W-1:2];
        wdata_reg     <= bus.wdata;
        wstrb_reg     <= bus.wstrb;
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    aw_done_next       = aw_done_reg;
    w_done_next        = w_done_reg;
    rdata_next         = rdata_reg;
    error_next         = error_reg;
    capture_req        = 1'b0;
    bus.m_axi_awvalid  = 1'b0;
    bus.m_axi_wvalid   = 1'b0;
    bus.m_axi_bready   = 1'b0;
    bus.m_axi_arvalid  = 1'b0;
    bus.m_axi_rready   = 1'b0;
    bus.ready          = 1'b0;

    case (state_reg)
      IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (bus.valid) begin
          capture_req = 1'b1;
          state_next  = (|bus.wstrb) ? WR_REQ : RD_REQ;
        end
      end
      // AW and W complete independently; leave only once both have handshaken.
      WR_REQ: begin
        bus.m_axi_awvalid = ~aw_done_reg;
        bus.m_axi_wvalid  = ~w_done_reg;
        if (!aw_done_reg && bus.m_axi_awready) aw_done_next = 1'b1;
        if (!w_done_reg && bus.m_axi_wready)   w_done_next  = 1'b1;
        if ((aw_done_reg || bus.m_axi_awready) && (w_done_reg || bus.m_axi_wready))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) begin
          error_next = error_reg | resp_is_error(bus.m_axi_bresp);
          state_next = DONE;
        end
      end
      RD_REQ: begin
        bus.m_axi_arvalid = 1'b1;
        if (bus.m_axi_arready) state_next = RD_RESP;
      end
      RD_RESP: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid) begin
          rdata_next = bus.m_axi_rdata;
          error_next = error_reg | resp_is_error(bus.m_axi_rresp);
          state_next = DONE;
        end
      end
      DONE: begin
        bus.ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.m_axi_awid    = AXI_ID_W'(AXI_ID);
  assign bus.m_axi_awaddr  = {word_addr_reg, 2'b00};
  assign bus.m_axi_awlen   = '0;
  assign bus.m_axi_awsize  = AXI_SIZE_W32;
  assign bus.m_axi_awburst = AXI_BURST_INCR;

  assign bus.m_axi_wdata   = wdata_reg;
  assign bus.m_axi_wstrb   = wstrb_reg;
  assign bus.m_axi_wlast   = 1'b1;

  assign bus.m_axi_arid    = AXI_ID_W'(AXI_ID);
  assign bus.m_axi_araddr  = {word_addr_reg, 2'b00};
  assign bus.m_axi_arlen   = '0;
  assign bus.m_axi_arsize  = AXI_SIZE_W32;
  assign bus.m_axi_arburst = AXI_BURST_INCR;

  assign bus.rdata = rdata_reg;
  assign bus.error = error_reg;

  // IDs and rlast carry no information with a single outstanding one-beat transfer.
  logic unused_inputs;
  assign unused_inputs = ^{bus.m_axi_bid, bus.m_axi_rid, bus.m_axi_rlast, bus.addr};

endmodule

// File: tb/tb_iob_axi_m_bridge.sv
// Drives random and directed native requests through the bridge into a small
// AXI memory with programmable stalls and compares against a word-level model.
module tb_iob_axi_m_bridge;

  logic clk;
  logic rst;

  iob_axi_m_bridge_if #(
    .ADDR_W(32), .DATA_W(32), .AXI_ADDR_W(24), .AXI_ID_W(4), .AXI_LEN_W(8)
  ) bus ();

  iob_axi_m_bridge #(
    .ADDR_W(32), .DATA_W(32), .AXI_ADDR_W(24), .AXI_ID_W(4), .AXI_LEN_W(8), .AXI_ID(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AXI memory with per-channel ready/valid delays
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  logic aw_have, w_have, ar_have;
  logic [23:0] aw_addr_q, last_awaddr, last_araddr;
  logic [7:0]  last_awlen, last_arlen;
  logic [2:0]  last_awsize, last_arsize;
  logic [1:0]  last_awburst, last_arburst;
  logic        last_wlast;
  logic [31:0] w_data_q, r_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  force_bresp = 2'b00, force_rresp = 2'b00;
  logic [31:0] ram [0:63];

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign bus.m_axi_awready = bus.m_axi_awvalid && !aw_have && (aw_cnt >= aw_delay);
  assign bus.m_axi_wready  = bus.m_axi_wvalid && !w_have && (w_cnt >= w_delay);
  assign bus.m_axi_bvalid  = aw_have && w_have && (b_cnt >= b_delay);
  assign bus.m_axi_bresp   = force_bresp;
  assign bus.m_axi_bid     = 4'h0;
  assign bus.m_axi_arready = bus.m_axi_arvalid && !ar_have && (ar_cnt >= ar_delay);
  assign bus.m_axi_rvalid  = ar_have && (r_cnt >= r_delay);
  assign bus.m_axi_rdata   = r_data_q;
  assign bus.m_axi_rresp   = force_rresp;
  assign bus.m_axi_rid     = 4'h5;
  assign bus.m_axi_rlast   = 1'b1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    end else begin
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_have <= 1'b1; aw_cnt <= 0; aw_n <= aw_n + 1;
        aw_addr_q <= bus.m_axi_awaddr; last_awaddr <= bus.m_axi_awaddr;
        last_awlen <= bus.m_axi_awlen; last_awsize <= bus.m_axi_awsize;
        last_awburst <= bus.m_axi_awburst;
      end else if (bus.m_axi_awvalid) aw_cnt <= aw_cnt + 1;

      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_have <= 1'b1; w_cnt <= 0; w_n <= w_n + 1;
        w_data_q <= bus.m_axi_wdata; w_strb_q <= bus.m_axi_wstrb; last_wlast <= bus.m_axi_wlast;
      end else if (bus.m_axi_wvalid) w_cnt <= w_cnt + 1;

      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        ram[aw_addr_q[7:2]] <= byte_merge(ram[aw_addr_q[7:2]], w_data_q, w_strb_q);
        aw_have <= 1'b0; w_have <= 1'b0; b_cnt <= 0; b_n <= b_n + 1;
      end else if (aw_have && w_have) b_cnt <= b_cnt + 1;

      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_have <= 1'b1; ar_cnt <= 0; ar_n <= ar_n + 1;
        r_data_q <= ram[bus.m_axi_araddr[7:2]]; last_araddr <= bus.m_axi_araddr;
        last_arlen <= bus.m_axi_arlen; last_arsize <= bus.m_axi_arsize;
        last_arburst <= bus.m_axi_arburst;
      end else if (bus.m_axi_arvalid) ar_cnt <= ar_cnt + 1;

      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        ar_have <= 1'b0; r_cnt <= 0; r_n <= r_n + 1;
      end else if (ar_have) r_cnt <= r_cnt + 1;
    end
  end

  // Protocol watch: a valid seen without ready must still be high next cycle
  int viol_n = 0, ready_n = 0;
  logic awv_q, awr_q, wv_q, wr_q, arv_q, arr_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      awv_q <= 1'b0; awr_q <= 1'b0; wv_q <= 1'b0; wr_q <= 1'b0; arv_q <= 1'b0; arr_q <= 1'b0;
    end else begin
      awv_q <= bus.m_axi_awvalid; awr_q <= bus.m_axi_awready;
      wv_q  <= bus.m_axi_wvalid;  wr_q  <= bus.m_axi_wready;
      arv_q <= bus.m_axi_arvalid; arr_q <= bus.m_axi_arready;
      if ((awv_q && !awr_q && !bus.m_axi_awvalid) || (wv_q && !wr_q && !bus.m_axi_wvalid) ||
          (arv_q && !arr_q && !bus.m_axi_arvalid))
        viol_n <= viol_n + 1;
      if (bus.ready) ready_n <= ready_n + 1;
    end
  end

  // Reference model: word memory, sticky error, last read data
  logic [31:0] model_mem [0:63];
  logic        model_err;
  logic [31:0] model_rdata;
  int          txn_id = 0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a & 32'h0000_00FF) >> 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_err   = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int lat);
    int aw0, w0, b0, ar0, r0, rdy0, k;
    logic [31:0] mask;
    aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n; rdy0 = ready_n;
    k = word_of(a);
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.ready && lat < 100);
    bus.valid = 1'b0;
    check_val("ready_seen", {31'b0, bus.ready}, 32'd1);
    if (s != 4'h0) begin
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
      model_mem[k] = (model_mem[k] & ~mask) | (d & mask);
      model_err = model_err | (force_bresp != 2'b00);
      check_val("aw_count", aw_n - aw0, 1);
      check_val("w_count", w_n - w0, 1);
      check_val("b_count", b_n - b0, 1);
      check_val("awaddr", {8'h0, last_awaddr}, a & 32'h00FF_FFFC);
      check_val("awlen", {24'h0, last_awlen}, 0);
      check_val("awsize", {29'h0, last_awsize}, 2);
      check_val("awburst", {30'h0, last_awburst}, 1);
      check_val("wlast", {31'h0, last_wlast}, 1);
      check_val("wstrb", {28'h0, w_strb_q}, {28'h0, s});
      check_val("wdata", w_data_q, d);
    end else begin
      model_err = model_err | (force_rresp != 2'b00);
      model_rdata = model_mem[k];
      check_val("ar_count", ar_n - ar0, 1);
      check_val("r_count", r_n - r0, 1);
      check_val("araddr", {8'h0, last_araddr}, a & 32'h00FF_FFFC);
      check_val("arlen", {24'h0, last_arlen}, 0);
      check_val("arsize_burst", {27'h0, last_arsize, last_arburst}, {27'h0, 3'd2, 2'b01});
    end
    check_val("rdata", bus.rdata, model_rdata);
    check_val("error", {31'b0, bus.error}, {31'b0, model_err});
    @(posedge clk); #1;
    check_val("ready_width", {31'b0, bus.ready}, 32'd0);
    check_val("ready_pulses", ready_n - rdy0, 1);
    $display("txn %0d %s addr=%h wdata=%h strb=%h rdata=%h lat=%0d err=%0b", txn_id,
             (s != 4'h0) ? "WR" : "RD", a, d, s, bus.rdata, lat, bus.error);
    txn_id++;
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  initial begin
    int lat, n;
    logic [31:0] a, d;
    logic [3:0]  s;
    bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
    model_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_ready", {31'b0, bus.ready}, 0);
    check_val("rst_error", {31'b0, bus.error}, 0);
    check_val("rst_rdata", bus.rdata, 0);
    check_val("rst_valids", {27'b0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                             bus.m_axi_bready, bus.m_axi_rready}, 0);
    rst = 1'b1;

    // Zero-wait write, read and partial-strobe overwrite
    set_delays(0, 0, 0, 0, 0);
    run_txn(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, lat);
    check_val("wr_latency", lat, 3);
    run_txn(32'h0000_0100, 32'h0, 4'h0, lat);
    check_val("rd_latency", lat, 3);
    check_val("rd_deadbeef", bus.rdata, 32'hDEAD_BEEF);
    run_txn(32'h0000_0100, 32'h0000_CAFE, 4'h3, lat);
    run_txn(32'h0000_0100, 32'h0, 4'h0, lat);
    check_val("rd_deadcafe", bus.rdata, 32'hDEAD_CAFE);

    // Stalled AW with immediate W, then the reverse
    set_delays(3, 0, 0, 0, 0);
    run_txn(32'h0000_0020, 32'h1234_5678, 4'hF, lat);
    check_val("aw_stall_latency", lat, 6);
    set_delays(0, 3, 0, 0, 0);
    run_txn(32'h0000_0024, 32'h9ABC_DEF0, 4'hF, lat);
    check_val("w_stall_latency", lat, 6);

    // Randomized mix with random stalls, ignored upper/low address bits
    for (int i = 0; i < 40; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      n = $urandom_range(0, 15);
      a = ($urandom() & 32'hFF00_0003) | (n << 2);
      d = $urandom();
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(a, d, s, lat);
    end

    // Error response is sticky through a later OKAY read
    set_delays(0, 0, 0, 0, 0);
    force_bresp = 2'b10;
    run_txn(32'h0000_0040, 32'h5555_AAAA, 4'hF, lat);
    check_val("err_set", {31'b0, bus.error}, 1);
    force_bresp = 2'b00;
    run_txn(32'h0000_0040, 32'h0, 4'h0, lat);
    check_val("err_sticky", {31'b0, bus.error}, 1);

    // Reset while waiting for R: everything drops at once, no ready follows
    set_delays(0, 0, 0, 0, 8);
    n = ready_n;
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = 32'h0000_0100; bus.wstrb = 4'h0;
    for (int i = 0; i < 20 && !bus.m_axi_rready; i++) @(negedge clk);
    check_val("reached_rd_resp", {31'b0, bus.m_axi_rready}, 1);
    bus.valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_val("mid_rst_drop", {28'b0, bus.m_axi_arvalid, bus.m_axi_rready, bus.ready,
                               bus.m_axi_awvalid}, 0);
    check_val("mid_rst_error", {31'b0, bus.error}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("no_ready_after_rst", ready_n - n, 0);
    set_delays(1, 0, 1, 1, 1);
    run_txn(32'h0000_0030, 32'hA5A5_0F0F, 4'hF, lat);
    set_delays(0, 0, 0, 0, 0);
    run_txn(32'h0000_0030, 32'h0, 4'h0, lat);
    check_val("post_rst_read", bus.rdata, 32'hA5A5_0F0F);
    check_val("valid_held_violations", viol_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
